// File: rtl/core_mmio_arbiter.sv
// Arbitrates the shared mtime/mtimecmp MMIO port between the LSU (r0) and the debug/host port (r1).
// Define CORE_MMIO_ARB_RR_EN for round-robin arbitration; otherwise r0 has fixed priority.
module core_mmio_arbiter #(
    parameter int RSP_LAT = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic        r0_wen,
    input  logic        r1_wen,
    input  logic [63:0] r0_addr,
    input  logic [63:0] r1_addr,
    input  logic [63:0] r0_wdata,
    input  logic [63:0] r1_wdata,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_rsp_valid,
    output logic        r1_rsp_valid,
    output logic [63:0] r0_rdata,
    output logic [63:0] r1_rdata,
    output logic        r0_error,
    output logic        r1_error,
    output logic        m_req,
    output logic        m_wen,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    input  logic        m_gnt,
    input  logic [63:0] m_rdata,
    input  logic        m_error,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam logic [2:0] P_LAT = 3'(RSP_LAT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_lat_ctr;
    logic [2:0]  w_lat_ctr_nxt;
    logic        r_owner;
    logic [63:0] r_buf_rdata;
    logic        r_buf_error;
    logic        w_sel_valid;
    logic        w_sel;
    logic        w_gnt;
    logic        w_capture;

`ifdef CORE_MMIO_ARB_RR_EN
    logic r_last;

    // last starts at 1 so the first conflict after reset goes to r0
    always_ff @(posedge g_clk) begin
        if (!g_resetn)
            r_last <= 1'b1;
        else if (w_gnt)
            r_last <= w_sel;
    end

    assign w_sel = (r0_req && r1_req) ? ~r_last : r1_req;
`else
    assign w_sel = ~r0_req;
`endif

    // Nothing is presented downstream while a transaction is outstanding or in reset
    assign w_sel_valid = g_resetn && (r_state != ST_WAIT) && (r0_req || r1_req);
    assign w_gnt       = w_sel_valid && m_gnt;

    assign m_req   = w_sel_valid;
    assign m_wen   = w_sel_valid && (w_sel ? r1_wen : r0_wen);
    assign m_addr  = w_sel_valid ? (w_sel ? r1_addr : r0_addr) : 64'd0;
    assign m_wdata = w_sel_valid ? (w_sel ? r1_wdata : r0_wdata) : 64'd0;

    assign r0_gnt = w_gnt && !w_sel;
    assign r1_gnt = w_gnt && w_sel;

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_ctr_nxt = r_lat_ctr;
        w_capture     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_state_nxt   = ST_WAIT;
                    w_lat_ctr_nxt = 3'd1;
                end
            end
            ST_WAIT: begin
                w_lat_ctr_nxt = r_lat_ctr + 3'd1;
                if (r_lat_ctr == P_LAT) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (w_gnt) begin
                    w_state_nxt   = ST_WAIT;
                    w_lat_ctr_nxt = 3'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state     <= ST_IDLE;
            r_lat_ctr   <= 3'd0;
            r_owner     <= 1'b0;
            r_buf_rdata <= 64'd0;
            r_buf_error <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_ctr <= w_lat_ctr_nxt;
            if (w_gnt)
                r_owner <= w_sel;
            if (w_capture) begin
                r_buf_rdata <= m_rdata;
                r_buf_error <= m_error;
            end
        end
    end

    // Owner is updated on a grant in RSP, but the strobe still reflects the finishing owner
    assign r0_rsp_valid = (r_state == ST_RSP) && !r_owner;
    assign r1_rsp_valid = (r_state == ST_RSP) && r_owner;
    assign r0_rdata     = r_buf_rdata;
    assign r1_rdata     = r_buf_rdata;
    assign r0_error     = r_buf_error;
    assign r1_error     = r_buf_error;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_core_mmio_arbiter.sv
// Directed bench for core_mmio_arbiter; responses are checked against an expected queue.
module tb_core_mmio_arbiter;

    localparam int LAT = 3;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        r0_req, r1_req, r0_wen, r1_wen;
    logic [63:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        m_gnt, m_error;
    logic [63:0] m_rdata;

    logic        r0_gnt, r1_gnt, r0_rsp_valid, r1_rsp_valid, r0_error, r1_error;
    logic [63:0] r0_rdata, r1_rdata;
    logic        m_req, m_wen;
    logic [63:0] m_addr, m_wdata;
    logic [1:0]  dbg_state;

    logic        a_r0_gnt, a_r1_gnt, a_r0_rsp_valid, a_r1_rsp_valid, a_r0_error, a_r1_error;
    logic [63:0] a_r0_rdata, a_r1_rdata;
    logic        a_m_req, a_m_wen;
    logic [63:0] a_m_addr, a_m_wdata;
    logic [1:0]  a_dbg_state;

    int          total = 0;
    int          bad = 0;
    logic [66:0] exp_q[$];

    always #5 g_clk = ~g_clk;

    core_mmio_arbiter #(.RSP_LAT(LAT)) u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .r0_req(r0_req), .r1_req(r1_req), .r0_wen(r0_wen), .r1_wen(r1_wen),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rsp_valid(r0_rsp_valid), .r1_rsp_valid(r1_rsp_valid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata), .r0_error(r0_error), .r1_error(r1_error),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rdata(m_rdata), .m_error(m_error), .o_dbg_state(dbg_state)
    );

    core_mmio_arbiter #(.RSP_LAT(1)) u_dut1 (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .r0_req(r0_req), .r1_req(r1_req), .r0_wen(r0_wen), .r1_wen(r1_wen),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(a_r0_gnt), .r1_gnt(a_r1_gnt), .r0_rsp_valid(a_r0_rsp_valid), .r1_rsp_valid(a_r1_rsp_valid),
        .r0_rdata(a_r0_rdata), .r1_rdata(a_r1_rdata), .r0_error(a_r0_error), .r1_error(a_r1_error),
        .m_req(a_m_req), .m_wen(a_m_wen), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_gnt(m_gnt), .m_rdata(m_rdata), .m_error(m_error), .o_dbg_state(a_dbg_state)
    );

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic e0, input logic e1);
        chk(tag, {65'd0, r0_gnt, r1_gnt}, {65'd0, e0, e1});
    endtask

    // Expected response word: {r1_rsp_valid, r0_rsp_valid, error, rdata}
    task automatic exp_push(input logic owner, input logic err, input logic [63:0] data);
        exp_q.push_back({owner, ~owner, err, data});
    endtask

    task automatic poll_rsp();
        logic [66:0] obs;
        logic [66:0] e;
        if (r0_rsp_valid || r1_rsp_valid) begin
            obs = {r1_rsp_valid, r0_rsp_valid,
                   r1_rsp_valid ? r1_error : r0_error,
                   r1_rsp_valid ? r1_rdata : r0_rdata};
            e = (exp_q.size() == 0) ? 67'd0 : exp_q.pop_front();
            chk("rsp", obs, e);
        end
    endtask

    task automatic nxt();
        @(posedge g_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge g_clk);
        poll_rsp();
    endtask

    task automatic step();
        nxt();
        smp();
    endtask

    initial begin
        logic e1;
        g_resetn = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0; r0_wen = 1'b0; r1_wen = 1'b0;
        r0_addr = 64'd0; r1_addr = 64'd0; r0_wdata = 64'd0; r1_wdata = 64'd0;
        m_gnt = 1'b1; m_rdata = 64'd0; m_error = 1'b0;

        repeat (3) step();
        chk("rst_ctl", {58'd0, r0_gnt, r1_gnt, r0_rsp_valid, r1_rsp_valid, m_req, m_wen,
                        r0_error, r1_error, dbg_state}, 67'd0);
        chk("rst_addr", {3'd0, m_addr}, 67'd0);
        chk("rst_rdata", {3'd0, r0_rdata | r1_rdata | m_wdata}, 67'd0);
        nxt(); g_resetn = 1'b1; smp();

        // conflict: both requesters held for four transactions
        nxt(); r0_req = 1'b1; r1_req = 1'b1; r0_addr = 64'h100; r1_addr = 64'h200; smp();
        for (int k = 0; k < 4; k++) begin
`ifdef CORE_MMIO_ARB_RR_EN
            e1 = k[0];
`else
            e1 = 1'b0;
`endif
            chk_gnt("cf_gnt", !e1, e1);
            chk("cf_addr", {3'd0, m_addr}, e1 ? 67'h200 : 67'h100);
            exp_push(e1, 1'b0, 64'hC0 + 64'(k));
            nxt();
            m_rdata = 64'hC0 + 64'(k);
            if (k == 3) begin r0_req = 1'b0; r1_req = 1'b0; end
            smp();
            chk_gnt("cf_wait", 1'b0, 1'b0);
            for (int j = 1; j < LAT; j++) begin step(); chk_gnt("cf_wait", 1'b0, 1'b0); end
            step();
        end
        repeat (LAT + 2) step();
        chk("cf_drain", 67'(exp_q.size()), 67'd0);

        // single read, also watched on the RSP_LAT=1 instance
        nxt(); r0_req = 1'b1; r0_addr = 64'h1000; m_rdata = 64'h2A; smp();
        chk_gnt("rd_gnt", 1'b1, 1'b0);
        chk("rd_mreq", {66'd0, m_req}, 67'd1);
        chk("rd_addr", {3'd0, m_addr}, 67'h1000);
        chk("rd1_gnt", {65'd0, a_r0_gnt, a_r1_gnt}, 67'b10);
        exp_push(1'b0, 1'b0, 64'h2A);
        nxt(); r0_req = 1'b0; smp();
        chk("rd_mreq_wait", {66'd0, m_req}, 67'd0);
        chk("rd1_rsp_early", {65'd0, a_r0_rsp_valid, a_r1_rsp_valid}, 67'd0);
        nxt(); smp();
        chk("rd1_rsp", {a_r1_rsp_valid, a_r0_rsp_valid, a_r0_error, a_r0_rdata}, {2'b01, 1'b0, 64'h2A});
        chk("rd_rsp_early", {65'd0, r0_rsp_valid, r1_rsp_valid}, 67'd0);
        for (int j = 3; j <= LAT; j++) begin
            step();
            chk("rd_rsp_early", {65'd0, r0_rsp_valid, r1_rsp_valid}, 67'd0);
        end
        step();
        chk("rd_rsp_time", {65'd0, r0_rsp_valid, r1_rsp_valid}, 67'b10);
        repeat (2) step();

        // request arriving while a transaction is outstanding
        nxt(); r0_req = 1'b1; r0_addr = 64'h2000; m_rdata = 64'h77; smp();
        chk_gnt("wt_first", 1'b1, 1'b0);
        exp_push(1'b0, 1'b0, 64'h77);
        nxt(); r0_req = 1'b0; r1_req = 1'b1; r1_addr = 64'h3000; smp();
        chk_gnt("wt_block", 1'b0, 1'b0);
        for (int j = 2; j <= LAT; j++) begin step(); chk_gnt("wt_block", 1'b0, 1'b0); end
        step();
        chk_gnt("wt_gnt", 1'b0, 1'b1);
        chk("wt_rsp_same", {66'd0, r0_rsp_valid}, 67'd1);
        exp_push(1'b1, 1'b0, 64'h88);
        nxt(); r1_req = 1'b0; m_rdata = 64'h88; smp();
        repeat (LAT + 2) step();

        // stalled downstream
        nxt(); m_gnt = 1'b0; r0_req = 1'b1; r0_addr = 64'h4000; m_rdata = 64'h99; smp();
        for (int j = 0; j < 5; j++) begin
            if (j > 0) step();
            chk_gnt("st_nognt", 1'b0, 1'b0);
            chk("st_mreq", {66'd0, m_req}, 67'd1);
            chk("st_state", {65'd0, dbg_state}, 67'd0);
        end
        nxt(); m_gnt = 1'b1; smp();
        chk_gnt("st_gnt", 1'b1, 1'b0);
        exp_push(1'b0, 1'b0, 64'h99);
        nxt(); r0_req = 1'b0; smp();
        repeat (LAT + 2) step();

        // write with downstream error
        nxt(); r1_req = 1'b1; r1_wen = 1'b1; r1_addr = 64'h1008; r1_wdata = 64'h55;
        m_error = 1'b1; m_rdata = 64'hDEAD; smp();
        chk_gnt("wr_gnt", 1'b0, 1'b1);
        chk("wr_wen", {66'd0, m_wen}, 67'd1);
        chk("wr_wdata", {3'd0, m_wdata}, 67'h55);
        chk("wr_addr", {3'd0, m_addr}, 67'h1008);
        exp_push(1'b1, 1'b1, 64'hDEAD);
        nxt(); r1_req = 1'b0; r1_wen = 1'b0; smp();
        chk("wr_wen_wait", {66'd0, m_wen}, 67'd0);
        repeat (LAT + 2) step();

        // reset while a transaction is outstanding
        nxt(); m_error = 1'b0; r0_req = 1'b1; r0_addr = 64'h5000; m_rdata = 64'h1234; smp();
        chk_gnt("mr_gnt", 1'b1, 1'b0);
        nxt(); r0_req = 1'b0; g_resetn = 1'b0; smp();
        nxt(); g_resetn = 1'b1; smp();
        chk("mr_ctl", {58'd0, r0_gnt, r1_gnt, r0_rsp_valid, r1_rsp_valid, m_req, m_wen,
                       r0_error, r1_error, dbg_state}, 67'd0);
        chk("mr_rdata", {3'd0, r0_rdata | r1_rdata}, 67'd0);
        repeat (LAT + 2) step();
        nxt(); r0_req = 1'b1; r1_req = 1'b1; smp();
        chk_gnt("mr_conflict", 1'b1, 1'b0);
        exp_push(1'b0, 1'b0, 64'h1234);
        nxt(); r0_req = 1'b0; r1_req = 1'b0; smp();
        repeat (LAT + 2) step();

        chk("final_drain", 67'(exp_q.size()), 67'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_mmio_arbiter.md
# core_mmio_arbiter

Shares the single memory-mapped counter/timer port (mtime, mtimecmp) between two requesters: requester 0 is the core load/store unit, requester 1 is the debug/host port. Only one transaction is outstanding at a time. Each transaction is tracked for a fixed downstream response latency, and the read data and error are returned to the owning requester through a registered response buffer. The block sits between the memory-access front end and the counter block's MMIO interface.

## Interface
- RSP_LAT, 1: cycles from downstream accept to valid m_rdata/m_error; legal range 1..7.
- g_clk  in  1  global clock
- g_resetn  in  1  reset; synchronous, active-low; clock g_clk
- r0_req, r1_req  in  1  requester request; held stable until granted
- r0_wen, r1_wen  in  1  write enable
- r0_addr, r1_addr  in  64  address
- r0_wdata, r1_wdata  in  64  write data
- r0_gnt, r1_gnt  out  1  request accepted this cycle (combinational)
- r0_rsp_valid, r1_rsp_valid  out  1  one-cycle response strobe to the owner
- r0_rdata, r1_rdata  out  64  response data; both driven from the shared response buffer
- r0_error, r1_error  out  1  response error; both driven from the shared response buffer
- m_req  out  1  downstream request
- m_wen  out  1  downstream write enable
- m_addr  out  64  downstream address
- m_wdata  out  64  downstream write data
- m_gnt  in  1  downstream accept
- m_rdata  in  64  downstream read data
- m_error  in  1  downstream error

## Operation
- **States:**
  - IDLE: no transaction outstanding.
  - WAIT: a transaction is outstanding.
  - RSP: a response is being presented.
  - Reset state is IDLE.
- **Grant-eligible states:** IDLE and RSP. No grant is given in WAIT.
- **Selection:**
  - The winner is chosen among the asserted rN_req (see Configuration).
  - The winner's wen/addr/wdata are driven combinationally onto m_*, with m_req=1.
  - When no requester is selected, m_* outputs are 0.
- **Grant:** rN_gnt = selected & m_req & m_gnt. On a grant:
  - owner <= N;
  - lat_ctr (3 bits) <= 1;
  - state -> WAIT.
- **WAIT:**
  - m_req=0.
  - lat_ctr increments each cycle.
  - When lat_ctr==RSP_LAT: capture m_rdata/m_error into the response buffer, then state -> RSP.
  - With RSP_LAT=1, the capture happens in the first WAIT cycle.
- **RSP:**
  - r[owner]_rsp_valid=1; the other requester's rsp_valid is 0.
  - A new grant in RSP goes to WAIT; otherwise the state returns to IDLE.
- **Response buffer:** holds its value until the next capture; rN_rdata/rN_error are valid only while rsp_valid is high.
- **m_gnt=0:** no grant is given. The request stays presented and selection is re-evaluated next cycle; the round-robin pointer is unchanged.
- **Reset mid-transaction:** the outstanding transaction is dropped with no response. State -> IDLE, buffer=0, owner=0, last=1.
- **Output reset values:** all outputs 0.

## Timing
- Grant in cycle T.
- Downstream data is captured at T+RSP_LAT.
- rN_rsp_valid is high at T+RSP_LAT+1.
- The next grant is possible at T+RSP_LAT+1, so back-to-back throughput is one transaction per RSP_LAT+1 cycles.
- Requests arriving during WAIT see gnt=0 until the RSP cycle.
- Granted requests are never cancelled; the requester may drop req after the gnt cycle.

## Configuration
- **Macro:** CORE_MMIO_ARB_RR_EN.
- **Defined:** round-robin arbitration.
  - A 1-bit `last` register records the most recent grantee and is updated only on a grant.
  - When both requesters assert req, the winner is !last; otherwise the single requester wins.
  - last resets to 1, so requester 0 wins the first conflict.
- **Undefined:** fixed priority, requester 0 always wins. The `last` register is not implemented.

## Test plan
- **Single read:** RSP_LAT=1, r0 reads addr 0x1000, downstream returns 0x2A with m_gnt=1 -> r0_gnt at T, m_req only at T, r0_rsp_valid at T+2 with rdata=0x2A, error=0; r1_rsp_valid stays 0.
- **Conflict:**
  - Both requesters assert req continuously for 4 transactions (RR_EN defined) -> grant order r0, r1, r0, r1, one every RSP_LAT+1 cycles.
  - Same stimulus with the macro undefined -> r0 is granted all 4.
- **Request during WAIT:** RSP_LAT=3, r1 asserts req at T+1 after an r0 grant at T -> r1_gnt=0 through T+3; r1_gnt=1 at T+4, coinciding with r0_rsp_valid.
- **Stalled downstream:** m_gnt=0 for 5 cycles with r0_req=1 -> no gnt and no state change; the grant occurs in the first cycle m_gnt=1.
- **Error and write:** r1 writes 0x55 to 0x1008, downstream returns m_error=1 -> r1_rsp_valid with error=1; m_wen=1 and m_wdata=0x55 in the grant cycle.
- **Reset mid-operation:** g_resetn low for 1 cycle during WAIT -> no rsp_valid afterwards, all outputs 0, and the next conflict is granted to r0.
